fifo_wr_arbiter: RTL and testbench
==================================

// Module: fifo_wr_arbiter
// PURPOSE
//  Round-robin arbiter sharing the single write port of syn_fifo among
//  NUM_REQ producers. Each producer uses a valid/ready handshake.
//  A grant is held for up to BURST_MAX beats, then passes to the next requester.
//  Sits between producer blocks and the FIFO; drives write_en/data_in and
//  honours the FIFO full flag. Also keeps a saturating count of stall cycles.
// PARAMETERS
//  NUM_REQ    4   number of requesters (2..8)
//  DATA_W     8   data width, matches the FIFO data_in width
//  BURST_MAX  4   max beats per grant (>=1)
// PORTS
//  clk             in   1                clock, all logic on posedge
//  rst             in   1                synchronous reset, active-high
//  req_valid       in   NUM_REQ          per-requester data valid
//  req_data        in   NUM_REQ*DATA_W   requester i data in bits [i*DATA_W +: DATA_W]
//  req_ready       out  NUM_REQ          per-requester accept (onehot or zero)
//  fifo_full       in   1                FIFO full flag (combinational from FIFO)
//  fifo_write_en   out  1                FIFO write enable
//  fifo_data_in    out  DATA_W           FIFO write data
//  grant_valid     out  1                1 while in GRANT state
//  grant_id        out  clog2(NUM_REQ)   current owner index
//  stall_cnt       out  16               cycles owner valid but fifo_full, saturating
// BEHAVIOUR
//  State: IDLE / GRANT. Registers: owner, last_owner, beat_cnt (clog2(BURST_MAX+1)), stall_cnt.
//  Reset values: state=IDLE, owner=0, last_owner=NUM_REQ-1, beat_cnt=0, stall_cnt=0.
//   So requester 0 has first priority after reset.
//  Outputs:
//   - req_ready[owner] = GRANT && !fifo_full; all other ready bits are 0.
//   - xfer = GRANT && req_valid[owner] && !fifo_full.
//   - fifo_write_en = xfer (combinational).
//   - fifo_data_in = req_data slice[owner].
//   - grant_valid = (state==GRANT); grant_id = owner.
//   - During reset all outputs read 0.
//  RR search: starts at last_owner+1 mod NUM_REQ; picks the first set req_valid bit, with wrap.
//  IDLE: if any req_valid, go to GRANT next cycle with owner=RR pick, beat_cnt=0.
//   No transfer occurs in IDLE (1-cycle arbitration latency).
//  GRANT, per cycle:
//   - xfer: beat_cnt+1.
//   - fifo_full && req_valid[owner]: hold grant, no timeout; stall_cnt+1, saturating at 16'hFFFF.
//   - Release when (a) xfer && beat_cnt==BURST_MAX-1, or (b) !req_valid[owner].
//  On release, last_owner<=owner and re-arbitrate in the same cycle, with no bubble:
//   - if RR pick (from owner+1) exists, stay in GRANT with the new owner, beat_cnt=0;
//   - else go to IDLE.
//   - In case (a) the old owner wins again only if it is the sole valid requester.
//  Producer rule: hold req_data stable while valid && !ready. Dropping valid forfeits the grant.
//  fifo_full rising mid-burst: stall with grant held; the burst resumes after full clears.
//  The beat count is not reset by stalls.
//  Reset mid-burst: next cycle state is IDLE, no write_en, and in-flight beats are abandoned.
//  Writes are never issued while fifo_full=1.
// TESTING
//  1 Reset, then req_valid=4'b0101 continuous, BURST_MAX=4, full=0.
//    -> req0 gets 4 beats, then req2 gets 4 beats, alternating, no gap between grants.
//  2 Single requester req3 valid forever.
//    -> grant_id stays 3, re-granted every 4 beats, fifo_write_en stays 1 after first grant cycle.
//  3 req1 granted, fifo_full=1 for 5 cycles mid-burst after 2 beats.
//    -> write_en=0, ready=0, stall_cnt+=5; then exactly 2 more beats before release.
//  4 req0 drops valid after 1 beat while req1,req2 valid.
//    -> same cycle re-arbitration picks req1; the next grant goes to req2.
//  5 Assert rst for 1 cycle mid-burst with full=0.
//    -> all outputs 0, state IDLE; first grant after reset goes to the lowest valid index.
//  6 Force full with req valid for 70000 cycles.
//    -> stall_cnt saturates at 65535; FIFO contents show per-requester order preserved with no loss.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ valid/ready producers.
// Grants last up to BURST_MAX beats and hand over with no bubble; stalls on fifo_full are counted.
module fifo_wr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 8,
    parameter int BURST_MAX = 4,
    localparam int ID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int BC_W     = $clog2(BURST_MAX + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      fifo_full,
    output logic                      fifo_write_en,
    output logic [DATA_W-1:0]         fifo_data_in,
    output logic                      grant_valid,
    output logic [ID_W-1:0]           grant_id,
    output logic [15:0]               stall_cnt
);
    typedef enum logic {S_IDLE, S_GRANT} state_t;

    state_t            r_state;
    logic [ID_W-1:0]   r_owner;
    logic [ID_W-1:0]   r_last_owner;
    logic [BC_W-1:0]   r_beat_cnt;
    logic [15:0]       r_stall_cnt;

    // {found, index}: first valid requester after 'last', wrapping back to 'last' itself.
    function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                              input logic [ID_W-1:0]   last);
        logic [ID_W:0] res;
        int            idx;
        res = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            idx = (int'(last) + i) % NUM_REQ;
            if (v[idx]) res = {1'b1, ID_W'(idx)};
        end
        return res;
    endfunction

    logic              w_grant;
    logic              w_own_valid;
    logic              w_xfer;
    logic              w_release;
    logic [ID_W:0]     w_pick_idle;
    logic [ID_W:0]     w_pick_rel;

    assign w_grant     = (r_state == S_GRANT);
    assign w_own_valid = req_valid[r_owner];
    assign w_xfer      = w_grant && w_own_valid && !fifo_full;
    assign w_release   = w_grant && ((w_xfer && (r_beat_cnt == BC_W'(BURST_MAX - 1))) || !w_own_valid);
    assign w_pick_idle = rr_pick(req_valid, r_last_owner);
    assign w_pick_rel  = rr_pick(req_valid, r_owner);

    // Outputs are forced to zero while reset is asserted, even before the reset edge lands.
    assign req_ready     = (!rst && w_grant && !fifo_full) ? (NUM_REQ'(1) << r_owner) : '0;
    assign fifo_write_en = !rst && w_xfer;
    assign fifo_data_in  = rst ? '0 : req_data[r_owner*DATA_W +: DATA_W];
    assign grant_valid   = !rst && w_grant;
    assign grant_id      = rst ? '0 : r_owner;
    assign stall_cnt     = rst ? '0 : r_stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_owner      <= '0;
            r_last_owner <= ID_W'(NUM_REQ - 1);
            r_beat_cnt   <= '0;
            r_stall_cnt  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pick_idle[ID_W]) begin
                        r_state    <= S_GRANT;
                        r_owner    <= w_pick_idle[ID_W-1:0];
                        r_beat_cnt <= '0;
                    end
                end
                S_GRANT: begin
                    if (w_xfer) r_beat_cnt <= r_beat_cnt + 1'b1;
                    if (fifo_full && w_own_valid && r_stall_cnt != 16'hFFFF)
                        r_stall_cnt <= r_stall_cnt + 16'd1;
                    // Hand over in the same cycle; the old owner only wins back if alone.
                    if (w_release) begin
                        r_last_owner <= r_owner;
                        r_beat_cnt   <= '0;
                        if (w_pick_rel[ID_W]) r_owner <= w_pick_rel[ID_W-1:0];
                        else                  r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: burst rotation, re-grant, stall, drop, reset and saturation.
module tb_fifo_wr_arbiter;
    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 8;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      fifo_full;
    logic                      fifo_write_en;
    logic [DATA_W-1:0]         fifo_data_in;
    logic                      grant_valid;
    logic [1:0]                grant_id;
    logic [15:0]               stall_cnt;

    int checks = 0;
    int errors = 0;

    fifo_wr_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .BURST_MAX(4)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .fifo_full(fifo_full), .fifo_write_en(fifo_write_en),
        .fifo_data_in(fifo_data_in), .grant_valid(grant_valid), .grant_id(grant_id),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    // Leaves rst low at a negedge; the caller then drives inputs for the first post-reset cycle.
    task automatic do_reset();
        rst = 1'b1; req_valid = '0; fifo_full = 1'b0;
        nxt(); nxt();
        rst = 1'b0;
    endtask

    initial begin
        logic [1:0] exp_id;
        rst = 1'b1; req_valid = '0; fifo_full = 1'b0;
        req_data = {8'h13, 8'h12, 8'h11, 8'h10};

        // Reset state and test 1: req0/req2 alternate 4-beat bursts
        nxt(); #1;
        chk("rst_gv", grant_valid, 0); chk("rst_we", fifo_write_en, 0);
        chk("rst_stall", stall_cnt, 0); chk("rst_ready", req_ready, 0);
        do_reset();
        req_valid = 4'b0101; #1;
        chk("t1_idle_gv", grant_valid, 0); chk("t1_idle_we", fifo_write_en, 0);
        for (int k = 1; k <= 12; k++) begin
            nxt(); #1;
            exp_id = (((k - 1) / 4) % 2 == 1) ? 2'd2 : 2'd0;
            chk("t1_id", grant_id, exp_id);
            chk("t1_we", fifo_write_en, 1);
            chk("t1_data", fifo_data_in, 8'h10 + exp_id);
            chk("t1_ready", req_ready, 4'b0001 << exp_id);
        end

        // Test 2: sole requester 3 re-granted without a gap
        do_reset();
        req_valid = 4'b1000; #1;
        chk("t2_idle_we", fifo_write_en, 0);
        for (int k = 1; k <= 10; k++) begin
            nxt(); #1;
            chk("t2_id", grant_id, 3); chk("t2_we", fifo_write_en, 1);
        end

        // Test 3: req1 stalls 5 cycles after 2 beats, then 2 beats, then req2
        do_reset();
        req_valid = 4'b0110; #1;
        for (int k = 1; k <= 2; k++) begin
            nxt(); #1;
            chk("t3_pre_id", grant_id, 1); chk("t3_pre_we", fifo_write_en, 1);
        end
        for (int k = 0; k < 5; k++) begin
            nxt(); fifo_full = 1'b1; #1;
            chk("t3_st_we", fifo_write_en, 0); chk("t3_st_ready", req_ready, 0);
            chk("t3_st_id", grant_id, 1);      chk("t3_st_gv", grant_valid, 1);
        end
        for (int k = 0; k < 2; k++) begin
            nxt(); fifo_full = 1'b0; #1;
            chk("t3_post_id", grant_id, 1); chk("t3_post_we", fifo_write_en, 1);
        end
        chk("t3_stall", stall_cnt, 5);
        nxt(); #1;
        chk("t3_next_id", grant_id, 2);

        // Test 4: req0 drops valid after one beat
        do_reset();
        req_valid = 4'b0111; #1;
        nxt(); #1;
        chk("t4_b0_id", grant_id, 0); chk("t4_b0_we", fifo_write_en, 1);
        nxt(); req_valid = 4'b0110; #1;
        chk("t4_drop_we", fifo_write_en, 0); chk("t4_drop_id", grant_id, 0);
        for (int k = 0; k < 4; k++) begin
            nxt(); #1;
            chk("t4_r1_id", grant_id, 1); chk("t4_r1_we", fifo_write_en, 1);
        end
        nxt(); #1;
        chk("t4_r2_id", grant_id, 2);

        // Test 5: reset mid-burst
        do_reset();
        req_valid = 4'b1100; #1;
        nxt(); #1; chk("t5_b_id", grant_id, 2);
        nxt(); #1; chk("t5_b_we", fifo_write_en, 1);
        nxt(); rst = 1'b1; #1;
        chk("t5_rst_gv", grant_valid, 0); chk("t5_rst_we", fifo_write_en, 0);
        chk("t5_rst_ready", req_ready, 0); chk("t5_rst_id", grant_id, 0);
        chk("t5_rst_data", fifo_data_in, 0); chk("t5_rst_stall", stall_cnt, 0);
        nxt(); rst = 1'b0; #1;
        chk("t5_idle_gv", grant_valid, 0); chk("t5_idle_we", fifo_write_en, 0);
        nxt(); #1;
        chk("t5_regrant_id", grant_id, 2); chk("t5_regrant_we", fifo_write_en, 1);

        // Test 6: long stall saturates the counter, then data flows again
        do_reset();
        req_valid = 4'b0001; fifo_full = 1'b1; #1;
        nxt(); #1;
        chk("t6_gv", grant_valid, 1); chk("t6_we", fifo_write_en, 0);
        chk("t6_ready", req_ready, 0);
        nxt(); #1;
        chk("t6_stall1", stall_cnt, 1);
        for (int k = 0; k < 70000; k++) nxt();
        #1;
        chk("t6_sat", stall_cnt, 16'hFFFF);
        chk("t6_sat_we", fifo_write_en, 0);
        nxt(); fifo_full = 1'b0; #1;
        chk("t6_resume_we", fifo_write_en, 1); chk("t6_resume_data", fifo_data_in, 8'h10);
        chk("t6_resume_id", grant_id, 0); chk("t6_hold_sat", stall_cnt, 16'hFFFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
